// File: rtl/pb_sequence_detector.sv
// Debounced push-button sequence detector: millisecond-tick debounce, press edges,
// and a three-state FSM that recognises PRESS_COUNT consecutive presses of one button.
module pb_sequence_detector #(
    parameter int NUM_BUTTONS   = 4,
    parameter int PRESS_COUNT   = 3,
    parameter int TICK_DIV      = 50000,
    parameter int DEBOUNCE_LEN  = 10,
    parameter int TIMEOUT_TICKS = 2000,
    localparam int BW = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1,
    localparam int CW = $clog2(PRESS_COUNT + 1)
) (
    input  logic                   CLOCK_50_I,
    input  logic                   resetn,
    input  logic [NUM_BUTTONS-1:0] PUSH_BUTTON_N_I,
    output logic [NUM_BUTTONS-1:0] pb_status_o,
    output logic [NUM_BUTTONS-1:0] pb_edge_o,
    output logic [1:0]             state_o,
    output logic [BW-1:0]          button_o,
    output logic [CW-1:0]          count_o,
    output logic                   match_o,
    output logic                   timeout_o,
    output logic                   display_o
);

    localparam int DW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW         = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
    localparam bit SINGLE     = (PRESS_COUNT == 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_TICKS != 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COUNTING = 2'd1,
        S_DISPLAY  = 2'd2
    } state_t;

    logic [DW-1:0]                          r_div;
    logic                                   r_tick;
    logic [NUM_BUTTONS-1:0][DEBOUNCE_LEN-1:0] r_shift;
    logic [NUM_BUTTONS-1:0]                 w_pressed;
    logic [NUM_BUTTONS-1:0]                 w_any_sample;
    logic [NUM_BUTTONS-1:0]                 r_status;
    logic [NUM_BUTTONS-1:0]                 r_edge;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [BW-1:0] r_button;
    logic [BW-1:0] w_button_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_nxt;
    logic [TW-1:0] w_to_inc;
    logic          r_match;
    logic          w_match_nxt;
    logic          r_timeout;
    logic          w_timeout_nxt;
    logic          w_edge_any;
    logic [BW-1:0] w_edge_idx;
    logic          w_own_edge;

    assign w_pressed = ~PUSH_BUTTON_N_I;

    // Debounce tick: one-cycle pulse every TICK_DIV clocks
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (r_div == DW'(TICK_DIV - 1)) begin
            r_div  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_div  <= r_div + DW'(1);
            r_tick <= 1'b0;
        end
    end

    // Per-button sample history, shifted once per tick
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_shift <= '0;
        end else if (r_tick) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                r_shift[i] <= (r_shift[i] << 1'b1) | DEBOUNCE_LEN'(w_pressed[i]);
            end
        end
    end

    // Any pressed sample in the window keeps the button pressed
    always_comb begin
        w_any_sample = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            w_any_sample[i] = |r_shift[i];
        end
    end

    // Debounced level and its rising edge; r_status doubles as the previous-status buffer
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_status <= '0;
            r_edge   <= '0;
        end else begin
            r_status <= w_any_sample;
            r_edge   <= w_any_sample & ~r_status;
        end
    end

    // Edge arbitration: lowest index wins, tracked-button edge flagged separately
    always_comb begin
        w_edge_any = |r_edge;
        w_edge_idx = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (r_edge[i]) begin
                w_edge_idx = BW'(i);
            end else begin
                w_edge_idx = w_edge_idx;
            end
        end
        w_own_edge = |(r_edge & (NUM_BUTTONS'(1'b1) << r_button));
        w_cnt_inc  = r_count + CW'(1);
        w_to_inc   = r_to_cnt + TW'(1);
    end

    // FSM state and sequence registers
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_button  <= '0;
            r_count   <= '0;
            r_to_cnt  <= '0;
            r_match   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_button  <= w_button_nxt;
            r_count   <= w_count_nxt;
            r_to_cnt  <= w_to_nxt;
            r_match   <= w_match_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_button_nxt  = r_button;
        w_count_nxt   = r_count;
        w_to_nxt      = r_to_cnt;
        w_match_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge_any) begin
                    w_button_nxt = w_edge_idx;
                    w_count_nxt  = CW'(1);
                    w_to_nxt     = '0;
                    if (SINGLE) begin
                        w_state_nxt = S_DISPLAY;
                        w_match_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_COUNTING;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_COUNTING: begin
                if (w_own_edge) begin
                    w_to_nxt = '0;
                    if (w_cnt_inc >= CW'(PRESS_COUNT)) begin
                        w_state_nxt = S_DISPLAY;
                        w_count_nxt = CW'(PRESS_COUNT);
                        w_match_nxt = 1'b1;
                    end else begin
                        w_count_nxt = w_cnt_inc;
                    end
                end else if (w_edge_any) begin
                    w_button_nxt = w_edge_idx;
                    w_count_nxt  = CW'(1);
                    w_to_nxt     = '0;
                end else if (r_tick && TIMEOUT_EN) begin
                    // Counter parks at the limit until the next sequence clears it
                    if (w_to_inc >= TW'(TIMEOUT_TICKS)) begin
                        w_state_nxt   = S_IDLE;
                        w_count_nxt   = '0;
                        w_to_nxt      = TW'(TIMEOUT_TICKS);
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_to_nxt = w_to_inc;
                    end
                end else begin
                    w_to_nxt = r_to_cnt;
                end
            end
            S_DISPLAY: begin
                if (w_edge_any) begin
                    w_button_nxt = w_edge_idx;
                    w_count_nxt  = CW'(1);
                    w_to_nxt     = '0;
                    if (SINGLE) begin
                        w_state_nxt = S_DISPLAY;
                        w_match_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_COUNTING;
                    end
                end else begin
                    w_state_nxt = S_DISPLAY;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_button_nxt = '0;
                w_count_nxt  = '0;
                w_to_nxt     = '0;
            end
        endcase
    end

    // FSM outputs, decoded from registers only
    always_comb begin
        pb_status_o = r_status;
        pb_edge_o   = r_edge;
        state_o     = r_state;
        button_o    = r_button;
        count_o     = r_count;
        match_o     = r_match;
        timeout_o   = r_timeout;
        display_o   = (r_state == S_DISPLAY);
    end

endmodule

// File: doc/pb_sequence_detector.md
# pb_sequence_detector

Parametrised debounced push-button sequence detector for the board-level FSM labs. It debounces NUM_BUTTONS active-low push buttons with an internal millisecond tick and produces one-cycle rising-edge pulses. It detects PRESS_COUNT consecutive presses of the same button, with an optional inter-press timeout and restart-on-other-button behaviour. Its outputs drive seven-segment and LED logic in the top level.

## Interface
- NUM_BUTTONS, 4: number of push buttons (1..8).
- PRESS_COUNT, 3: consecutive same-button presses needed for a match (1..15).
- TICK_DIV, 50000: clock cycles per debounce tick (1 kHz at 50 MHz; ≥2).
- DEBOUNCE_LEN, 10: debounce shift-register length in ticks (≥1).
- TIMEOUT_TICKS, 2000: ticks allowed between presses while counting; 0 disables the timeout.
- Derived widths: BW = max(1, clog2(NUM_BUTTONS)); CW = clog2(PRESS_COUNT+1).

Ports:
- CLOCK_50_I  in  1  system clock; the single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- PUSH_BUTTON_N_I  in  NUM_BUTTONS  raw buttons, active low.
- pb_status_o  out  NUM_BUTTONS  debounced pressed level (1 = pressed).
- pb_edge_o  out  NUM_BUTTONS  one-cycle pulse per debounced press.
- state_o  out  2  0 = S_IDLE, 1 = S_COUNTING, 2 = S_DISPLAY.
- button_o  out  BW  index of the tracked button.
- count_o  out  CW  presses accepted in the current sequence.
- match_o  out  1  one-cycle pulse on sequence completion.
- timeout_o  out  1  one-cycle pulse when a sequence is abandoned by timeout.
- display_o  out  1  high while in S_DISPLAY.

## Operation
- Tick counter: counts 0..TICK_DIV-1 and wraps. A one-cycle tick pulse is registered when the counter wraps.
- Debounce: on each tick, each button's shift register shifts in ~PUSH_BUTTON_N_I[i]. pb_status_o[i] is registered as the OR of the shift register. A status buffer holds the previous status; pb_edge_o = status & ~buffer.
  - Press recognition: the first tick that samples the button low.
  - Release recognition: DEBOUNCE_LEN consecutive released samples.
- Priority among simultaneous edges: the lowest index wins; the others are ignored that cycle.
- S_IDLE: on any edge on button b, go to S_COUNTING with button_o = b and count_o = 1. If PRESS_COUNT = 1, go directly to S_DISPLAY with a match instead.
- S_COUNTING:
  - Edge on button_o (this takes priority over other buttons): count_o + 1. If that equals PRESS_COUNT, go to S_DISPLAY and pulse match_o. The timeout counter clears.
  - Otherwise, edge on another button c: restart with button_o = c, count_o = 1, timeout counter cleared.
  - Otherwise, on a tick, the timeout counter increments. When it reaches TIMEOUT_TICKS (nonzero), go to S_IDLE, clear count_o and pulse timeout_o.
- S_DISPLAY: hold button_o and count_o = PRESS_COUNT. Any edge on button b restarts to S_COUNTING with button_o = b and count_o = 1, including when b is the same button. There is no timeout in this state.
- Arithmetic: count_o never exceeds PRESS_COUNT. The timeout counter saturates at TIMEOUT_TICKS.

## Timing
- Reset: every register and output is 0. This gives state_o = S_IDLE, all shift registers 0, the tick counter 0, and no pulses.
- Reset mid-sequence: returns immediately (asynchronously) to the reset values. Held buttons are re-detected as new presses after reset deasserts.
- Latency, with the tick pulse high in cycle T sampling a pressed button:
  - The shift register updates at the end of T.
  - pb_status_o and pb_edge_o are high in cycle T+2; the edge pulse lasts exactly one cycle.
  - state_o, count_o, match_o and timeout_o update in cycle T+3.
- match_o and timeout_o are registered one-cycle pulses coincident with the state change.
- A held button produces exactly one edge. A release shorter than DEBOUNCE_LEN ticks produces no new edge.

## Test plan
Bench parameters for all scenarios: NUM_BUTTONS = 4, PRESS_COUNT = 3, TICK_DIV = 4, DEBOUNCE_LEN = 3, TIMEOUT_TICKS = 20.
- Reset and basic debounce: assert resetn low mid-run, then check all outputs are 0. Press button 2 and hold it for 10 ticks → exactly one pb_edge_o = 4'b0100 pulse, in cycle T+2 after the sampling tick.
- Three presses of button 1, each held 5 ticks and released 5 ticks → count_o goes 1, 2, 3; state_o = 2; match_o pulses once; button_o = 1; display_o = 1.
- Button 0 pressed twice, then button 3 pressed → state_o = 1, button_o = 3, count_o = 1, no match. Then press button 3 twice more → match_o pulses.
- Button 2 pressed once, then no input for 25 ticks → timeout_o pulses at the 20th tick after the press was accepted; state_o = 0, count_o = 0.
- Simultaneous edges on buttons 1 and 3 in S_IDLE → button_o = 1. A glitch released for 1 tick within a hold → no extra edge.
- In S_DISPLAY, press the same button → state_o = 1 with count_o = 1. Assert reset mid-sequence → all outputs return to 0 asynchronously.
